bcd_to_binary: RTL and testbench

- Multi-cycle converter from packed BCD to unsigned binary, using reverse double-dabble (shift right, then subtract 3 from each nibble ≥ 8).
- It is the inverse path of the score display chain. It turns operator-entered or preset BCD scores (e.g. from DIP/keypad digit entry) into the binary score counters used by game logic.
- Uses the same start/completed handshake as the binary-to-BCD converter.

---
 rtl/scoreboard_pkg.sv | 26 ++
 rtl/bcd_nibble_adjust.sv | 21 ++
 rtl/bcd_to_binary.sv | 139 +++++++++++++
 tb/tb_bcd_to_binary.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// ============================================================================
// Module      : scoreboard_pkg
// Description : Shared types and constants for the score conversion blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int BCD_ADJUST    = 3;

    function automatic logic is_valid_bcd_digit(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit <= BCD_DIGIT_W'(BCD_MAX_DIGIT));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
// ============================================================================
// Module      : bcd_nibble_adjust
// Description : Reverse double-dabble digit correction: subtract 3 when >= 8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_nibble_adjust
    import scoreboard_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nibble_in,
    output logic [BCD_DIGIT_W-1:0] nibble_out
);

    // A nibble >= 8 after the shift carries a borrowed ten that must become five.
    assign nibble_out = nibble_in[BCD_DIGIT_W-1] ? (nibble_in - BCD_DIGIT_W'(BCD_ADJUST))
                                                 : nibble_in;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
// ============================================================================
// Module      : bcd_to_binary
// Description : Multi-cycle packed-BCD to unsigned binary converter using
//               reverse double-dabble with a start/completed handshake.
// Options     : BCD_CHECK_EN - reject inputs containing a digit above 9.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary
    import scoreboard_pkg::*;
#(
    parameter int N_DIGITS      = 2,
    parameter int OUTPUT_LENGTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [N_DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic [OUTPUT_LENGTH-1:0]        binary,
    output logic                            completed,
    output logic                            busy,
    output logic                            overflow,
    output logic                            invalid
);

    localparam int BCD_W = N_DIGITS * BCD_DIGIT_W;
    localparam int R_W   = BCD_W + OUTPUT_LENGTH;
    localparam int CNT_W = $clog2(OUTPUT_LENGTH) + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [R_W-1:0]     r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic [R_W-1:0]     w_shifted;
    logic [R_W-1:0]     w_adjusted;
    logic               w_last;
    logic               w_bcd_bad;

    assign w_shifted = r_work >> 1;
    assign w_adjusted[OUTPUT_LENGTH-1:0] = w_shifted[OUTPUT_LENGTH-1:0];
    assign w_last = (r_cnt == CNT_W'(OUTPUT_LENGTH - 1));
    assign busy   = (r_state != IDLE);

    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
            bcd_nibble_adjust u_adjust (
                .nibble_in  (w_shifted[OUTPUT_LENGTH + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .nibble_out (w_adjusted[OUTPUT_LENGTH + i*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_CHECK_EN
    logic r_bad;

    always_comb begin
        w_bcd_bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!is_valid_bcd_digit(bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                w_bcd_bad = 1'b1;
            end
        end
    end
`else
    assign w_bcd_bad = 1'b0;
    assign invalid   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = w_bcd_bad ? DONE : SHIFT;
            SHIFT:   if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_work    <= '0;
            r_cnt     <= '0;
            binary    <= '0;
            completed <= 1'b0;
            overflow  <= 1'b0;
`ifdef BCD_CHECK_EN
            r_bad     <= 1'b0;
            invalid   <= 1'b0;
`endif
        end else begin
            completed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= {bcd, {OUTPUT_LENGTH{1'b0}}};
                        r_cnt  <= '0;
`ifdef BCD_CHECK_EN
                        r_bad  <= w_bcd_bad;
`endif
                    end
                end
                SHIFT: begin
                    r_work <= w_adjusted;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    completed <= 1'b1;
`ifdef BCD_CHECK_EN
                    // A rejected operand leaves the previous result visible.
                    if (r_bad) begin
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                    end else begin
                        binary   <= r_work[OUTPUT_LENGTH-1:0];
                        overflow <= |r_work[R_W-1 -: BCD_W];
                        invalid  <= 1'b0;
                    end
`else
                    binary   <= r_work[OUTPUT_LENGTH-1:0];
                    overflow <= |r_work[R_W-1 -: BCD_W];
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
// ============================================================================
// Module      : tb_bcd_to_binary
// Description : Directed self-checking bench for bcd_to_binary (8-bit and
//               6-bit result instances). Honours BCD_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start6 = 1'b0;
    logic [7:0] bcd = 8'h00;
    logic [7:0] bcd6 = 8'h00;

    logic [7:0] binary;
    logic       completed, busy, overflow, invalid;
    logic [5:0] binary6;
    logic       completed6, busy6, overflow6, invalid6;

    int n_cmp = 0;
    int n_bad = 0;
    int n, nb, pulses;
    logic [7:0] seen;

    bcd_to_binary #(.N_DIGITS(2), .OUTPUT_LENGTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .bcd(bcd),
        .binary(binary), .completed(completed), .busy(busy),
        .overflow(overflow), .invalid(invalid)
    );

    bcd_to_binary #(.N_DIGITS(2), .OUTPUT_LENGTH(6)) dut6 (
        .clock(clock), .reset(reset), .start(start6), .bcd(bcd6),
        .binary(binary6), .completed(completed6), .busy(busy6),
        .overflow(overflow6), .invalid(invalid6)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed=no completed pulse expected=pulse within budget", tag);
    endtask

    // Edges counted from the load edge until completed is seen; busy sampled per cycle.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_cycles++;
            step();
            edges++;
            if (completed) return;
        end
        timeout("wait_done");
    endtask

    task automatic wait_done6(output int edges);
        edges = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            edges++;
            if (completed6) return;
        end
        timeout("wait_done6");
    endtask

    task automatic convert(input logic [7:0] v);
        bcd = v;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n, nb);
    endtask

    task automatic convert6(input logic [7:0] v);
        bcd6 = v;
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        wait_done6(n);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_binary", binary, 0);
        check("rst_completed", completed, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_invalid", invalid, 0);
        check("rst_binary6", binary6, 0);
        step();
        reset = 1'b0;
        step();

        // Single conversion of 42
        bcd = 8'h42;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_busy_load", busy, 1);
        wait_done(n, nb);
        check("t1_latency", n, 9);
        check("t1_busy_cycles", nb, 9);
        check("t1_binary", binary, 42);
        check("t1_overflow", overflow, 0);
        check("t1_invalid", invalid, 0);
        check("t1_busy_done", busy, 0);
        step();
        check("t1_pulse_width", completed, 0);

        // Back-to-back with start held; bcd changes right after the first load
        bcd = 8'h99;
        start = 1'b1;
        step();
        bcd = 8'h00;
        wait_done(n, nb);
        check("t2_latency", n, 9);
        check("t2_binary_99", binary, 99);
        wait_done(n, nb);
        start = 1'b0;
        check("t2_spacing", n, 10);
        check("t2_binary_0", binary, 0);
        check("t2_overflow", overflow, 0);

        // Extra directed vectors across digit boundaries
        convert(8'h80); check("v_80", binary, 80);
        convert(8'h19); check("v_19", binary, 19);
        convert(8'h09); check("v_09", binary, 9);

        // 6-bit result instance: overflow and boundary values
        convert6(8'h99);
        check("t3_latency6", n, 7);
        check("t3_binary6_99", binary6, 35);
        check("t3_overflow6_99", overflow6, 1);
        convert6(8'h63);
        check("t3_binary6_63", binary6, 63);
        check("t3_overflow6_63", overflow6, 0);
        convert6(8'h64);
        check("t3_binary6_64", binary6, 0);
        check("t3_overflow6_64", overflow6, 1);

        // Start while busy is ignored
        bcd = 8'h25;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        bcd = 8'h10;
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        seen = 8'hFF;
        for (int k = 0; k < 15; k++) begin
            step();
            if (completed) begin
                pulses++;
                seen = binary;
            end
        end
        check("t4_pulses", pulses, 1);
        check("t4_binary", seen, 25);

        // Reset mid-conversion aborts immediately
        bcd = 8'h57;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_binary", binary, 0);
        check("t5_rst_completed", completed, 0);
        check("t5_rst_overflow", overflow, 0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (completed) pulses++;
        end
        check("t5_no_pulse", pulses, 0);
        convert(8'h57);
        check("t5_latency", n, 9);
        check("t5_binary", binary, 57);

`ifdef BCD_CHECK_EN
        // Invalid digit: straight to DONE, previous result retained
        convert(8'h42);
        check("t6_prev", binary, 42);
        convert(8'h3A);
        check("t6_latency", n, 1);
        check("t6_invalid", invalid, 1);
        check("t6_binary", binary, 42);
        check("t6_overflow", overflow, 0);
        step();
        check("t6_idle", busy, 0);
        convert(8'h11);
        check("t6_valid_invalid", invalid, 0);
        check("t6_valid_binary", binary, 11);
`else
        check("t6_invalid_tied", invalid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
